// File: rtl/ms_delay_sequencer_pkg.sv
// ms_delay_sequencer_pkg: state encoding and standard game delays in ms
package ms_delay_sequencer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_PAUSE} state_t;
  localparam int LED_ON_MS        = 500;
  localparam int LED_GAP_MS       = 250;
  localparam int INPUT_TIMEOUT_MS = 5000;
endpackage

// File: rtl/ms_delay_sequencer_if.sv
// ms_delay_sequencer_if: control/status bundle; pause exists only with MS_DELAY_SEQUENCER_PAUSE_EN
interface ms_delay_sequencer_if #(parameter int CNT_W = 16);
  logic             start, abort, ms_tick;
  logic             tick_enable, tick_rst_n, busy, done, aborted;
  logic [CNT_W-1:0] duration_ms, remaining_ms;
`ifdef MS_DELAY_SEQUENCER_PAUSE_EN
  logic             pause;
  modport master (output start, duration_ms, abort, ms_tick, pause,
                  input tick_enable, tick_rst_n, busy, done, aborted, remaining_ms);
  modport slave  (input start, duration_ms, abort, ms_tick, pause,
                  output tick_enable, tick_rst_n, busy, done, aborted, remaining_ms);
`else
  modport master (output start, duration_ms, abort, ms_tick,
                  input tick_enable, tick_rst_n, busy, done, aborted, remaining_ms);
  modport slave  (input start, duration_ms, abort, ms_tick,
                  output tick_enable, tick_rst_n, busy, done, aborted, remaining_ms);
`endif
endinterface

// File: rtl/ms_delay_sequencer.sv
// ms_delay_sequencer: counts 1 ms ticks down to a programmable delay; MS_DELAY_SEQUENCER_PAUSE_EN adds pause
module ms_delay_sequencer
  import ms_delay_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  ms_delay_sequencer_if.slave bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic             ten_q, ten_d, trn_q, trn_d;
  logic             pause;
`ifdef MS_DELAY_SEQUENCER_PAUSE_EN
  assign pause = bus.pause;
`else
  assign pause = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    ten_d     = ten_q;
    trn_d     = trn_q;
    case (state_q)
      ST_IDLE: if (bus.start && !bus.abort) begin
        // a zero duration passes through DONE with busy set, so done lands one cycle later
        state_d = (bus.duration_ms == '0) ? ST_DONE : ST_RUN;
        rem_d   = bus.duration_ms;
        busy_d  = 1'b1;
        ten_d   = bus.duration_ms != '0;
        trn_d   = bus.duration_ms != '0;
      end
      ST_RUN, ST_PAUSE: if (bus.abort) begin
        state_d   = ST_IDLE;
        rem_d     = '0;
        busy_d    = 1'b0;
        aborted_d = 1'b1;
        ten_d     = 1'b0;
        trn_d     = 1'b0;
      end else if (state_q == ST_PAUSE) begin
        state_d = pause ? ST_PAUSE : ST_RUN;
        ten_d   = !pause;
      end else if (pause) begin
        state_d = ST_PAUSE;
        ten_d   = 1'b0;
      end else if (bus.ms_tick && rem_q != '0) begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ten_d   = 1'b0;
          trn_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = busy_q;
        busy_d  = 1'b0;
        ten_d   = 1'b0;
        trn_d   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ten_q     <= 1'b0;
      trn_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      ten_q     <= ten_d;
      trn_q     <= trn_d;
    end
  end
  assign bus.remaining_ms = rem_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.aborted      = aborted_q;
  assign bus.tick_enable  = ten_q;
  assign bus.tick_rst_n   = trn_q;
endmodule

// File: tb/tb_ms_delay_sequencer.sv
// tb_ms_delay_sequencer: directed stimulus with a pulse scoreboard for done/aborted
module tb_ms_delay_sequencer;
  localparam int TP = 50;
  typedef struct {int kind; int cyc;} ev_t;
  logic clk = 1'b0, rst = 1'b1;
  int   cyc = 0, n_cmp = 0, n_err = 0;
  ev_t  sb[$];
  ms_delay_sequencer_if #(.CNT_W(16)) bus();
  ms_delay_sequencer #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
  endtask
  task automatic see_ev(input int kind);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_%s: pulse at cycle %0d, none expected", kind == 0 ? "done" : "aborted", cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_err++;
        $display("FAIL pulse_order: got kind %0d at cycle %0d expected kind %0d at cycle %0d", kind, cyc, e.kind, e.cyc);
      end
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.done) see_ev(0);
    if (bus.aborted) see_ev(1);
  end
  task automatic tick(input logic last);
    step(TP - 1);
    bus.ms_tick = 1'b1;
    if (last) expect_ev(0, cyc + 1);
    step(1);
    bus.ms_tick = 1'b0;
  endtask
  task automatic launch(input int dur);
    bus.start = 1'b1;
    bus.duration_ms = 16'(dur);
    step(1);
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.ms_tick = 1'b0; bus.duration_ms = '0;
`ifdef MS_DELAY_SEQUENCER_PAUSE_EN
    bus.pause = 1'b0;
`endif
    step(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rem", bus.remaining_ms, 0);
    chk("rst_trn", bus.tick_rst_n, 0);
    chk("rst_ten", bus.tick_enable, 0);
    rst = 1'b0;
    step(2);
    // spurious tick in IDLE
    bus.ms_tick = 1'b1; step(1); bus.ms_tick = 1'b0;
    chk("idle_tick_rem", bus.remaining_ms, 0);
    chk("idle_tick_busy", bus.busy, 0);
    // duration 3
    launch(3);
    chk("d3_busy", bus.busy, 1);
    chk("d3_rem0", bus.remaining_ms, 3);
    chk("d3_ten", bus.tick_enable, 1);
    chk("d3_trn", bus.tick_rst_n, 1);
    for (int i = 0; i < 3; i++) begin
      tick(i == 2);
      chk("d3_rem", bus.remaining_ms, 32'(2 - i));
    end
    chk("d3_done", bus.done, 1);
    chk("d3_done_busy", bus.busy, 0);
    chk("d3_done_trn", bus.tick_rst_n, 0);
    step(1);
    chk("d3_done_clr", bus.done, 0);
    // duration 0
    expect_ev(0, cyc + 2);
    launch(0);
    chk("d0_busy", bus.busy, 1);
    chk("d0_ten", bus.tick_enable, 0);
    step(1);
    chk("d0_busy_off", bus.busy, 0);
    chk("d0_ten2", bus.tick_enable, 0);
    step(1);
    // abort after 2 ticks, then a normal start of 2
    launch(5);
    tick(0); tick(0);
    chk("ab_rem", bus.remaining_ms, 3);
    bus.abort = 1'b1;
    expect_ev(1, cyc + 1);
    step(1);
    bus.abort = 1'b0;
    chk("ab_rem0", bus.remaining_ms, 0);
    chk("ab_busy", bus.busy, 0);
    launch(2);
    chk("d2_rem", bus.remaining_ms, 2);
    tick(0); tick(1);
    step(2);
    // abort coincident with final tick; restart while busy ignored
    launch(1);
    bus.start = 1'b1; bus.duration_ms = 16'd9;
    step(1);
    bus.start = 1'b0;
    chk("restart_ign", bus.remaining_ms, 1);
    bus.abort = 1'b1; bus.ms_tick = 1'b1;
    expect_ev(1, cyc + 1);
    step(1);
    bus.abort = 1'b0; bus.ms_tick = 1'b0;
    chk("abtick_done", bus.done, 0);
    step(2);
    // start during DONE ignored, accepted one cycle later
    launch(1);
    tick(1);
    bus.start = 1'b1; bus.duration_ms = 16'd4;
    step(1);
    chk("start_in_done", bus.busy, 0);
    step(1);
    bus.start = 1'b0;
    chk("start_after_done", bus.remaining_ms, 4);
    bus.abort = 1'b1;
    expect_ev(1, cyc + 1);
    step(1);
    bus.abort = 1'b0;
    step(1);
`ifdef MS_DELAY_SEQUENCER_PAUSE_EN
    launch(4);
    tick(0);
    bus.pause = 1'b1;
    step(100);
    bus.ms_tick = 1'b1; step(1); bus.ms_tick = 1'b0;
    step(99);
    chk("pz_rem", bus.remaining_ms, 3);
    chk("pz_ten", bus.tick_enable, 0);
    chk("pz_trn", bus.tick_rst_n, 1);
    chk("pz_busy", bus.busy, 1);
    bus.pause = 1'b0;
    step(1);
    chk("pz_resume", bus.tick_enable, 1);
    tick(0); tick(0); tick(1);
    step(2);
`endif
    // asynchronous reset mid-RUN
    launch(7);
    chk("r7_rem", bus.remaining_ms, 7);
    #2 rst = 1'b1;
    #1;
    chk("ar_rem", bus.remaining_ms, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_ten", bus.tick_enable, 0);
    chk("ar_trn", bus.tick_rst_n, 0);
    chk("ar_done", bus.done, 0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
